// File: rtl/app_mult_accumulator_if.sv
// Handshake bundle between the approximate-multiplier product stream, the
// frame accumulator and its downstream consumer.
interface app_mult_accumulator_if #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 5
);
    logic              start;
    logic [PROD_W-1:0] prod_in;
    logic              prod_valid;
    logic              prod_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              acc_valid;
    logic              acc_ready;
    logic              busy;
    logic              overflow;
    logic [CNT_W-1:0]  term_cnt;

    modport master (
        output start, prod_in, prod_valid, acc_ready,
        input  prod_ready, acc_out, acc_valid, busy, overflow, term_cnt
    );

    modport slave (
        input  start, prod_in, prod_valid, acc_ready,
        output prod_ready, acc_out, acc_valid, busy, overflow, term_cnt
    );
endinterface

// File: rtl/app_mult_accumulator.sv
// Frame MAC after the approximate multiplier: sums TERMS products per frame.
// Optional APP_MULT_ACC_SATURATE_EN clamps on carry instead of wrapping.
module app_mult_accumulator #(
    parameter int WIDTH1 = 8,
    parameter int WIDTH2 = 8,
    parameter int ACC_W  = 24,
    parameter int TERMS  = 16
) (
    input logic clk,
    input logic rst,
    app_mult_accumulator_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for start, acc_out keeps last frame result
    // ACC   | accepting products, prod_ready high
    // HOLD  | frame complete, acc_valid high until acc_ready
    localparam int PROD_W = WIDTH1 + WIDTH2;
    localparam int CNT_W  = $clog2(TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TERMS - 1);

    generate
        if (ACC_W < PROD_W) begin : g_bad_acc_w
            $error("app_mult_accumulator: ACC_W must be >= WIDTH1+WIDTH2");
        end
        if (TERMS < 1) begin : g_bad_terms
            $error("app_mult_accumulator: TERMS must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             acc_valid_q, acc_valid_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W:0]   sum;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        acc_valid_d = acc_valid_q;
        overflow_d  = overflow_q;
        cnt_d       = cnt_q;
        sum         = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.prod_in};
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = ACC;
                    acc_d      = '0;
                    cnt_d      = '0;
                    overflow_d = 1'b0;
                end
            end
            ACC: begin
                if (bus.prod_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (sum[ACC_W]) begin
                        overflow_d = 1'b1;
`ifdef APP_MULT_ACC_SATURATE_EN
                        acc_d = {ACC_W{1'b1}};
`else
                        acc_d = sum[ACC_W-1:0];
`endif
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                    end
                    if (cnt_q == LAST_CNT) begin
                        state_d     = HOLD;
                        acc_valid_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                // start seen on the release edge is dropped; IDLE samples it again
                if (bus.acc_ready) begin
                    state_d     = IDLE;
                    acc_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                acc_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            acc_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            acc_valid_q <= acc_valid_d;
            overflow_q  <= overflow_d;
            cnt_q       <= cnt_d;
        end
    end

    // prod_ready decodes state alone so upstream never sees a valid->ready loop
    assign bus.prod_ready = (state_q == ACC);
    assign bus.busy       = (state_q != IDLE);
    assign bus.acc_out    = acc_q;
    assign bus.acc_valid  = acc_valid_q;
    assign bus.overflow   = overflow_q;
    assign bus.term_cnt   = cnt_q;
endmodule

// File: tb/tb_app_mult_accumulator.sv
// Bench for app_mult_accumulator: four parameterisations share one product
// stream, each started independently; expectations come from tables and a sum model.
module tb_app_mult_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  start = '0;
    logic [15:0] prod_in = '0;
    logic        prod_valid = 1'b0;
    logic        acc_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    int terms_of [4] = '{16, 16, 8, 1};
    int accw_of  [4] = '{24, 18, 24, 24};
    int unsigned vals [16];

    always #5 clk = ~clk;

    app_mult_accumulator_if #(.PROD_W(16), .ACC_W(24), .CNT_W(5)) i0 ();
    app_mult_accumulator_if #(.PROD_W(16), .ACC_W(18), .CNT_W(5)) i1 ();
    app_mult_accumulator_if #(.PROD_W(16), .ACC_W(24), .CNT_W(4)) i2 ();
    app_mult_accumulator_if #(.PROD_W(16), .ACC_W(24), .CNT_W(1)) i3 ();

    app_mult_accumulator #(.WIDTH1(8), .WIDTH2(8), .ACC_W(24), .TERMS(16)) u0 (.clk(clk), .rst(rst), .bus(i0));
    app_mult_accumulator #(.WIDTH1(8), .WIDTH2(8), .ACC_W(18), .TERMS(16)) u1 (.clk(clk), .rst(rst), .bus(i1));
    app_mult_accumulator #(.WIDTH1(8), .WIDTH2(8), .ACC_W(24), .TERMS(8))  u2 (.clk(clk), .rst(rst), .bus(i2));
    app_mult_accumulator #(.WIDTH1(8), .WIDTH2(8), .ACC_W(24), .TERMS(1))  u3 (.clk(clk), .rst(rst), .bus(i3));

    assign i0.start = start[0];
    assign i1.start = start[1];
    assign i2.start = start[2];
    assign i3.start = start[3];
    assign i0.prod_in = prod_in;
    assign i1.prod_in = prod_in;
    assign i2.prod_in = prod_in;
    assign i3.prod_in = prod_in;
    assign i0.prod_valid = prod_valid;
    assign i1.prod_valid = prod_valid;
    assign i2.prod_valid = prod_valid;
    assign i3.prod_valid = prod_valid;
    assign i0.acc_ready = acc_ready;
    assign i1.acc_ready = acc_ready;
    assign i2.acc_ready = acc_ready;
    assign i3.acc_ready = acc_ready;

    logic [31:0] acc_o [4];
    logic [31:0] tc_o  [4];
    logic        av_o  [4];
    logic        pr_o  [4];
    logic        bz_o  [4];
    logic        ov_o  [4];

    assign acc_o[0] = 32'(i0.acc_out);
    assign acc_o[1] = 32'(i1.acc_out);
    assign acc_o[2] = 32'(i2.acc_out);
    assign acc_o[3] = 32'(i3.acc_out);
    assign tc_o[0] = 32'(i0.term_cnt);
    assign tc_o[1] = 32'(i1.term_cnt);
    assign tc_o[2] = 32'(i2.term_cnt);
    assign tc_o[3] = 32'(i3.term_cnt);
    assign av_o[0] = i0.acc_valid;
    assign av_o[1] = i1.acc_valid;
    assign av_o[2] = i2.acc_valid;
    assign av_o[3] = i3.acc_valid;
    assign pr_o[0] = i0.prod_ready;
    assign pr_o[1] = i1.prod_ready;
    assign pr_o[2] = i2.prod_ready;
    assign pr_o[3] = i3.prod_ready;
    assign bz_o[0] = i0.busy;
    assign bz_o[1] = i1.busy;
    assign bz_o[2] = i2.busy;
    assign bz_o[3] = i3.busy;
    assign ov_o[0] = i0.overflow;
    assign ov_o[1] = i1.overflow;
    assign ov_o[2] = i2.overflow;
    assign ov_o[3] = i3.overflow;

    typedef struct {
        int     sel;
        int     val;
        bit     gaps;
        bit     noise;
        int     hold;
        longint exp_acc;
        bit     exp_ovf;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int sel, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d expected %0d", name, sel, act, exp);
        end
    endtask

    // Reference: a frame result is the plain integer sum, reduced by the wrap/clamp rule.
    function automatic longint model_acc(input int sel);
        longint tot = 0;
        longint lim = longint'(1) << accw_of[sel];
        for (int k = 0; k < terms_of[sel]; k++) tot += longint'(vals[k]);
        if (tot < lim) return tot;
`ifdef APP_MULT_ACC_SATURATE_EN
        return lim - 1;
`else
        return tot % lim;
`endif
    endfunction

    function automatic bit model_ovf(input int sel);
        longint tot = 0;
        for (int k = 0; k < terms_of[sel]; k++) tot += longint'(vals[k]);
        return tot >= (longint'(1) << accw_of[sel]);
    endfunction

    task automatic check_reset_state();
        for (int s = 0; s < 4; s++) begin
            chk("rst_acc_out", s, acc_o[s], 0);
            chk("rst_acc_valid", s, av_o[s], 0);
            chk("rst_prod_ready", s, pr_o[s], 0);
            chk("rst_busy", s, bz_o[s], 0);
            chk("rst_overflow", s, ov_o[s], 0);
            chk("rst_term_cnt", s, tc_o[s], 0);
        end
    endtask

    task automatic run_frame(input int sel, input bit gaps, input bit noise, input int hold,
                             input longint exp_acc, input bit exp_ovf);
        int n = terms_of[sel];
        int i = 0;
        int cyc_n;
        bit hs;
        longint held;
        start[sel] = 1'b1;
        step();
        start[sel] = 1'b0;
        cyc_n = 1;
        chk("start_busy", sel, bz_o[sel], 1);
        chk("start_term_cnt", sel, tc_o[sel], 0);
        chk("start_overflow_clear", sel, ov_o[sel], 0);
        chk("start_acc_clear", sel, acc_o[sel], 0);
        while (!av_o[sel] && cyc_n < 200) begin
            prod_valid = gaps ? ((cyc_n % 2) == 1) : 1'b1;
            prod_in = (i < n) ? 16'(vals[i]) : 16'd0;
            if (noise) start[sel] = 1'($urandom_range(0, 1));
            chk("acc_prod_ready", sel, pr_o[sel], 1);
            hs = prod_valid && pr_o[sel];
            step();
            cyc_n++;
            if (hs) i++;
            chk("term_cnt_track", sel, tc_o[sel], i);
        end
        start[sel] = 1'b0;
        prod_valid = 1'b0;
        chk("acc_valid_seen", sel, av_o[sel], 1);
        if (!gaps) chk("frame_latency", sel, cyc_n, n + 1);
        chk("products_taken", sel, i, n);
        chk("acc_out", sel, acc_o[sel], exp_acc);
        chk("overflow", sel, ov_o[sel], exp_ovf);
        chk("final_term_cnt", sel, tc_o[sel], n);
        chk("hold_prod_ready", sel, pr_o[sel], 0);
        held = acc_o[sel];
        acc_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            prod_valid = 1'b1;
            prod_in = 16'hFFFF;
            start[sel] = 1'b1;
            step();
            chk("hold_acc_out", sel, acc_o[sel], held);
            chk("hold_acc_valid", sel, av_o[sel], 1);
            chk("hold_prod_ready", sel, pr_o[sel], 0);
            chk("hold_term_cnt", sel, tc_o[sel], n);
            chk("hold_overflow", sel, ov_o[sel], exp_ovf);
        end
        prod_valid = 1'b0;
        acc_ready = 1'b1;
        start[sel] = 1'b1;
        step();
        start[sel] = 1'b0;
        acc_ready = 1'b0;
        chk("release_busy", sel, bz_o[sel], 0);
        chk("release_acc_valid", sel, av_o[sel], 0);
        step();
        chk("idle_ignores_late_start", sel, bz_o[sel], 0);
        chk("idle_keeps_acc_out", sel, acc_o[sel], exp_acc);
        chk("idle_keeps_overflow", sel, ov_o[sel], exp_ovf);
    endtask

    vec_t tbl [7];

    initial begin
`ifdef APP_MULT_ACC_SATURATE_EN
        tbl[0] = '{0, 65025, 1'b0, 1'b0, 0, 1040400, 1'b0};
        tbl[1] = '{1, 65025, 1'b0, 1'b0, 2, 262143, 1'b1};
        tbl[4] = '{1, 16384, 1'b0, 1'b0, 0, 262143, 1'b1};
`else
        tbl[0] = '{0, 65025, 1'b0, 1'b0, 0, 1040400, 1'b0};
        tbl[1] = '{1, 65025, 1'b0, 1'b0, 2, 253968, 1'b1};
        tbl[4] = '{1, 16384, 1'b0, 1'b0, 0, 0, 1'b1};
`endif
        tbl[2] = '{2, 100, 1'b1, 1'b1, 0, 800, 1'b0};
        tbl[3] = '{3, 12345, 1'b0, 1'b0, 1, 12345, 1'b0};
        tbl[5] = '{1, 16383, 1'b1, 1'b0, 0, 262128, 1'b0};
        tbl[6] = '{0, 0, 1'b0, 1'b1, 3, 0, 1'b0};

        rst = 1'b1;
        repeat (3) step();
        check_reset_state();
        rst = 1'b0;
        step();

        for (int t = 0; t < 7; t++) begin
            for (int k = 0; k < 16; k++) vals[k] = tbl[t].val;
            run_frame(tbl[t].sel, tbl[t].gaps, tbl[t].noise, tbl[t].hold,
                      tbl[t].exp_acc, tbl[t].exp_ovf);
        end

        for (int k = 0; k < 16; k++) vals[k] = k + 1;
        run_frame(0, 1'b0, 1'b0, 5, 136, 1'b0);

        for (int r = 0; r < 10; r++) begin
            int sel = $urandom_range(0, 3);
            for (int k = 0; k < 16; k++) vals[k] = $urandom_range(0, 65535);
            run_frame(sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 4), model_acc(sel), model_ovf(sel));
        end

        // leave dut1 with a sticky overflow, then abort a dut0 frame with reset
        for (int k = 0; k < 16; k++) vals[k] = 65025;
        run_frame(1, 1'b0, 1'b0, 0, model_acc(1), 1'b1);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        prod_valid = 1'b1;
        prod_in = 16'd1000;
        repeat (7) step();
        prod_valid = 1'b0;
        chk("partial_term_cnt", 0, tc_o[0], 7);
        chk("partial_acc_out", 0, acc_o[0], 7000);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state();
        step();
        rst = 1'b0;
        step();
        check_reset_state();
        for (int k = 0; k < 16; k++) vals[k] = 2;
        run_frame(0, 1'b0, 1'b0, 1, 32, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
